// File: rtl/mem_access.sv
// mem_access: memory-access pipeline stage sitting directly after the ALU stage.
//
// Issues load/store transactions on a simple req/ack data-memory bus,
// places store data on byte lanes, sign/zero-extends load data and forwards
// all other instruction state to writeback. The pipeline is stalled while a
// bus transaction is outstanding.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   prev_*                     registered ALU-stage outputs (valid on prev_clk_en)
//   dmem_req/we/addr/wdata/wstrb  registered bus request, held until ack
//   dmem_ack, dmem_rdata       bus completion and read word (same cycle)
//   rd, rd_wdata, rd_w_en, rd_valid, pc, exception  writeback outputs
//   clk_en                     writeback outputs valid this cycle
//   stall                      holds the ALU stage and everything earlier

`ifndef OPCODE_WIDTH
  `define OPCODE_WIDTH 11
`endif
`ifndef LOAD
  `define LOAD 5
`endif
`ifndef STORE
  `define STORE 6
`endif
`ifndef EXCEPTION_WIDTH
  `define EXCEPTION_WIDTH 8
`endif
`ifndef LOAD_MISALIGNED
  `define LOAD_MISALIGNED 4
`endif
`ifndef STORE_MISALIGNED
  `define STORE_MISALIGNED 5
`endif
`ifndef LOAD_FAULT
  `define LOAD_FAULT 6
`endif
`ifndef STORE_FAULT
  `define STORE_FAULT 7
`endif

module mem_access #(
  parameter int unsigned OPCODE_WIDTH    = `OPCODE_WIDTH,
  parameter int unsigned EXCEPTION_WIDTH = `EXCEPTION_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES  = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       prev_clk_en,
  input  logic                       prev_flush,
  input  logic [OPCODE_WIDTH-1:0]    prev_opcode_type,
  input  logic [EXCEPTION_WIDTH-1:0] prev_exception,
  input  logic [2:0]                 prev_funct3,
  input  logic [31:0]                prev_alu_result,
  input  logic [31:0]                prev_rs2_data,
  input  logic [4:0]                 prev_rd,
  input  logic [31:0]                prev_rd_wdata,
  input  logic                       prev_rd_w_en,
  input  logic                       prev_rd_valid,
  input  logic [31:0]                prev_pc,
  output logic                       dmem_req,
  output logic                       dmem_we,
  output logic [31:0]                dmem_addr,
  output logic [31:0]                dmem_wdata,
  output logic [3:0]                 dmem_wstrb,
  input  logic                       dmem_ack,
  input  logic [31:0]                dmem_rdata,
  output logic [4:0]                 rd,
  output logic [31:0]                rd_wdata,
  output logic                       rd_w_en,
  output logic                       rd_valid,
  output logic [31:0]                pc,
  output logic [EXCEPTION_WIDTH-1:0] exception,
  output logic                       clk_en,
  output logic                       stall
);

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_e;

  state_e                     state_q;
  logic [31:0]                cnt_q;

  logic                       dmem_req_q;
  logic                       dmem_we_q;
  logic [31:0]                dmem_addr_q;
  logic [31:0]                dmem_wdata_q;
  logic [3:0]                 dmem_wstrb_q;

  logic [4:0]                 rd_q;
  logic [31:0]                rd_wdata_q;
  logic                       rd_w_en_q;
  logic                       rd_valid_q;
  logic [31:0]                pc_q;
  logic [EXCEPTION_WIDTH-1:0] exception_q;
  logic                       clk_en_q;

  // Instruction state captured at accept, consumed when the access ends.
  logic                       pend_load_q;
  logic [2:0]                 pend_funct3_q;
  logic [1:0]                 pend_off_q;
  logic [4:0]                 pend_rd_q;
  logic [31:0]                pend_rd_wdata_q;
  logic                       pend_rd_w_en_q;
  logic                       pend_rd_valid_q;
  logic [31:0]                pend_pc_q;
  logic [EXCEPTION_WIDTH-1:0] pend_exc_q;

  logic                       is_load;
  logic                       is_store;
  logic                       is_mem;
  logic                       accept;
  logic                       misaligned;
  logic                       timeout_hit;
  logic [1:0]                 off;
  logic [EXCEPTION_WIDTH-1:0] mis_exc;
  logic [EXCEPTION_WIDTH-1:0] fault_exc;
  logic [31:0]                st_wdata;
  logic [3:0]                 st_wstrb;
  logic [7:0]                 ld_byte;
  logic [15:0]                ld_half;
  logic [31:0]                ld_data;

  // Only the LOAD/STORE bits of the opcode type matter here.
  logic unused_opcode;
  assign unused_opcode = ^prev_opcode_type;

  always_comb begin
    is_load  = prev_opcode_type[`LOAD];
    is_store = prev_opcode_type[`STORE];
    is_mem   = is_load | is_store;
    accept   = (state_q == IDLE) && prev_clk_en && !prev_flush;
    off      = prev_alu_result[1:0];

    misaligned = 1'b0;
    if (is_mem) begin
      case (prev_funct3[1:0])
        2'b01:   misaligned = off[0];
        2'b10:   misaligned = (off != 2'b00);
        default: misaligned = 1'b0;
      endcase
    end

    mis_exc = '0;
    if (misaligned) begin
      if (is_load) mis_exc[`LOAD_MISALIGNED]  = 1'b1;
      else         mis_exc[`STORE_MISALIGNED] = 1'b1;
    end

    fault_exc = '0;
    if (pend_load_q) fault_exc[`LOAD_FAULT]  = 1'b1;
    else             fault_exc[`STORE_FAULT] = 1'b1;
  end

  // Store lane placement.
  always_comb begin
    case (prev_funct3[1:0])
      2'b00: begin
        st_wdata = {4{prev_rs2_data[7:0]}};
        st_wstrb = 4'b0001 << off;
      end
      2'b01: begin
        st_wdata = {2{prev_rs2_data[15:0]}};
        st_wstrb = 4'b0011 << off;
      end
      default: begin
        st_wdata = prev_rs2_data;
        st_wstrb = 4'b1111;
      end
    endcase
  end

  // Load extraction and extension, using the offset/size captured at accept.
  always_comb begin
    case (pend_off_q)
      2'd0:    ld_byte = dmem_rdata[7:0];
      2'd1:    ld_byte = dmem_rdata[15:8];
      2'd2:    ld_byte = dmem_rdata[23:16];
      default: ld_byte = dmem_rdata[31:24];
    endcase
    ld_half = pend_off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (pend_funct3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'b0, ld_byte};
      3'b101:  ld_data = {16'b0, ld_half};
      default: ld_data = dmem_rdata;
    endcase
  end

  // The counter holds the number of completed ack-less REQ cycles, so the
  // limit is hit on the edge that would make it equal TIMEOUT_CYCLES.
  always_comb begin
    timeout_hit = (TIMEOUT_CYCLES != 0) && (state_q == REQ) && !dmem_ack &&
                  (cnt_q == TIMEOUT_CYCLES - 1);
  end

  assign stall = (state_q == REQ) && !dmem_ack && !timeout_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      dmem_req_q      <= 1'b0;
      dmem_we_q       <= 1'b0;
      dmem_addr_q     <= '0;
      dmem_wdata_q    <= '0;
      dmem_wstrb_q    <= '0;
      rd_q            <= '0;
      rd_wdata_q      <= '0;
      rd_w_en_q       <= 1'b0;
      rd_valid_q      <= 1'b0;
      pc_q            <= '0;
      exception_q     <= '0;
      clk_en_q        <= 1'b0;
      pend_load_q     <= 1'b0;
      pend_funct3_q   <= '0;
      pend_off_q      <= '0;
      pend_rd_q       <= '0;
      pend_rd_wdata_q <= '0;
      pend_rd_w_en_q  <= 1'b0;
      pend_rd_valid_q <= 1'b0;
      pend_pc_q       <= '0;
      pend_exc_q      <= '0;
    end else begin
      clk_en_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (is_mem && !misaligned) begin
              state_q         <= REQ;
              cnt_q           <= '0;
              dmem_req_q      <= 1'b1;
              dmem_we_q       <= !is_load;
              dmem_addr_q     <= {prev_alu_result[31:2], 2'b00};
              dmem_wdata_q    <= is_load ? '0 : st_wdata;
              dmem_wstrb_q    <= is_load ? '0 : st_wstrb;
              pend_load_q     <= is_load;
              pend_funct3_q   <= prev_funct3;
              pend_off_q      <= off;
              pend_rd_q       <= prev_rd;
              pend_rd_wdata_q <= prev_rd_wdata;
              pend_rd_w_en_q  <= prev_rd_w_en;
              pend_rd_valid_q <= prev_rd_valid;
              pend_pc_q       <= prev_pc;
              pend_exc_q      <= prev_exception;
            end else begin
              clk_en_q    <= 1'b1;
              rd_q        <= prev_rd;
              rd_wdata_q  <= prev_rd_wdata;
              rd_w_en_q   <= prev_rd_w_en & !misaligned;
              rd_valid_q  <= prev_rd_valid;
              pc_q        <= prev_pc;
              exception_q <= prev_exception | mis_exc;
            end
          end
        end
        REQ: begin
          if (dmem_ack) begin
            state_q     <= IDLE;
            dmem_req_q  <= 1'b0;
            clk_en_q    <= 1'b1;
            rd_q        <= pend_rd_q;
            rd_wdata_q  <= pend_load_q ? ld_data : pend_rd_wdata_q;
            rd_w_en_q   <= pend_load_q & pend_rd_w_en_q;
            rd_valid_q  <= pend_load_q | pend_rd_valid_q;
            pc_q        <= pend_pc_q;
            exception_q <= pend_exc_q;
          end else if (timeout_hit) begin
            state_q     <= IDLE;
            dmem_req_q  <= 1'b0;
            clk_en_q    <= 1'b1;
            rd_q        <= pend_rd_q;
            rd_wdata_q  <= pend_rd_wdata_q;
            rd_w_en_q   <= 1'b0;
            rd_valid_q  <= pend_rd_valid_q;
            pc_q        <= pend_pc_q;
            exception_q <= pend_exc_q | fault_exc;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign dmem_wstrb = dmem_wstrb_q;
  assign rd         = rd_q;
  assign rd_wdata   = rd_wdata_q;
  assign rd_w_en    = rd_w_en_q;
  assign rd_valid   = rd_valid_q;
  assign pc         = pc_q;
  assign exception  = exception_q;
  assign clk_en     = clk_en_q;

endmodule
